// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice summed per stage,
// with the carry registered between stages and valid/ready handshakes on both ends.
module adder_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             ovf
);

   localparam int NS  = WIDTH / CHUNK;
   localparam int MSB = WIDTH - 1;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic [NS-1:0]    v_r;
   logic [NS-1:0]    c_r;
   logic [NS-1:0]    sa_r;
   logic [NS-1:0]    sb_r;
   logic [WIDTH-1:0] a_r [NS];
   logic [WIDTH-1:0] b_r [NS];
   logic [WIDTH-1:0] s_r [NS];
   logic [CHUNK:0]   slice_sum [NS];

   // The whole pipeline advances as one; a stalled output freezes every stage.
   assign adv      = !v_r[NS-1] || out_ready;
   assign in_ready = adv;

   always_comb begin
      b_eff        = sub ? ~B : B;
      slice_sum[0] = {1'b0, A[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, C_in};
      for (int k = 1; k < NS; k++) begin
         slice_sum[k] = {1'b0, a_r[k-1][k*CHUNK +: CHUNK]}
                        + {1'b0, b_r[k-1][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, c_r[k-1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_r  <= '0;
         c_r  <= '0;
         sa_r <= '0;
         sb_r <= '0;
         for (int k = 0; k < NS; k++) begin
            a_r[k] <= '0;
            b_r[k] <= '0;
            s_r[k] <= '0;
         end
      end else if (adv) begin
         v_r[0]             <= in_valid;
         a_r[0]             <= A;
         b_r[0]             <= b_eff;
         s_r[0]             <= '0;
         s_r[0][CHUNK-1:0]  <= slice_sum[0][CHUNK-1:0];
         c_r[0]             <= slice_sum[0][CHUNK];
         sa_r[0]            <= A[MSB];
         sb_r[0]            <= b_eff[MSB];
         // Completed lower slices ride along; each stage fills in its own slice.
         for (int k = 1; k < NS; k++) begin
            v_r[k]                   <= v_r[k-1];
            a_r[k]                   <= a_r[k-1];
            b_r[k]                   <= b_r[k-1];
            s_r[k]                   <= s_r[k-1];
            s_r[k][k*CHUNK +: CHUNK] <= slice_sum[k][CHUNK-1:0];
            c_r[k]                   <= slice_sum[k][CHUNK];
            sa_r[k]                  <= sa_r[k-1];
            sb_r[k]                  <= sb_r[k-1];
         end
      end
   end

   assign out_valid = v_r[NS-1];
   assign S         = s_r[NS-1];
   assign C_out     = c_r[NS-1];
   assign ovf       = (sa_r[NS-1] == sb_r[NS-1]) && (S[MSB] != sa_r[NS-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and streaming checks for adder_pipe at WIDTH=32, CHUNK=8 (four stages).
module tb_adder_pipe;

   localparam int W  = 32;
   localparam int CH = 8;
   localparam int NS = W / CH;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, C_in, sub;
   logic         out_valid, out_ready, C_out, ovf;
   logic [W-1:0] A, B, S;

   int checks = 0;
   int errors = 0;
   logic [W+1:0] exp_q [$];

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .C_in(C_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .C_out(C_out), .ovf(ovf)
   );

   // Reference: {ovf, C_out, S} for A + (sub ? ~B : B) + C_in
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sb);
      logic [W-1:0] bb;
      logic [W:0]   r;
      bb = sb ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
      return {(a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]), r};
   endfunction

   task automatic test_reset;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; C_in = 1'b0; sub = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, S, C_out, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b S=%h C=%b ovf=%b, want all 0",
                  out_valid, S, C_out, ovf);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sb,
                              input logic [W-1:0] es, input logic ec, input logic eo);
      int edges;
      @(negedge clk);
      A = a; B = b; C_in = cin; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_in_ready: got %b, want 1", name, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      edges = 1;
      while (out_valid !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      checks++;
      if (edges !== NS) begin
         errors++;
         $display("FAIL %s_latency: got %0d edges, want %0d", name, edges, NS);
      end
      checks++;
      if ({S, C_out, ovf} !== {es, ec, eo}) begin
         errors++;
         $display("FAIL %s_result: got S=%h C=%b ovf=%b, want S=%h C=%b ovf=%b",
                  name, S, C_out, ovf, es, ec, eo);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int sent = 0, got = 0, first = -1, last = -1;
      logic [W-1:0] a, b;
      logic cin, sb;
      logic [W+1:0] e;
      exp_q.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra: unexpected result S=%h at cycle %0d", S, c);
            end else begin
               e = exp_q.pop_front();
               if ({ovf, C_out, S} !== e) begin
                  errors++;
                  $display("FAIL b2b_result%0d: got ovf=%b C=%b S=%h, want ovf=%b C=%b S=%h",
                           got, ovf, C_out, S, e[W+1], e[W], e[W-1:0]);
               end
            end
            got++;
            if (first < 0) first = c;
            last = c;
         end
         if (sent < 10) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sb = 1'($urandom);
            A = a; B = b; C_in = cin; sub = sb; in_valid = 1'b1;
            exp_q.push_back(ref_add(a, b, cin, sb));
            sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      checks++;
      if (got !== 10 || (last - first) !== 9) begin
         errors++;
         $display("FAIL b2b_count: got %0d results over span %0d, want 10 over span 9",
                  got, last - first);
      end
   endtask

   task automatic test_stall;
      int sent = 0, got = 0, n_stall = 0;
      logic pending = 1'b0, stalled_prev = 1'b0;
      logic [W+1:0] snap, e;
      logic [W-1:0] a, b;
      logic cin, sb;
      exp_q.delete();
      a = '0; b = '0; cin = 1'b0; sb = 1'b0; snap = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         out_ready = !(c >= 8 && c < 14);
         #1;
         if (out_valid === 1'b1 && out_ready === 1'b0) begin
            n_stall++;
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready: got %b at cycle %0d, want 0", in_ready, c);
            end
            if (stalled_prev) begin
               checks++;
               if ({ovf, C_out, S} !== snap) begin
                  errors++;
                  $display("FAIL stall_stable: got %h at cycle %0d, want %h", {ovf, C_out, S}, c, snap);
               end
            end
            snap = {ovf, C_out, S};
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stall_extra: unexpected result S=%h at cycle %0d", S, c);
            end else begin
               e = exp_q.pop_front();
               if ({ovf, C_out, S} !== e) begin
                  errors++;
                  $display("FAIL stall_result%0d: got %h, want %h", got, {ovf, C_out, S}, e);
               end
            end
            got++;
         end
         if (sent < 12) begin
            if (!pending) begin
               a = $urandom; b = $urandom; cin = 1'($urandom); sb = 1'($urandom);
            end
            A = a; B = b; C_in = cin; sub = sb; in_valid = 1'b1;
            if (in_ready === 1'b1) begin
               exp_q.push_back(ref_add(a, b, cin, sb));
               sent++;
               pending = 1'b0;
            end else begin
               pending = 1'b1;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      checks++;
      if (got !== 12 || n_stall !== 6 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL stall_count: got %0d results, %0d stall cycles, %0d left; want 12, 6, 0",
                  got, n_stall, exp_q.size());
      end
   endtask

   task automatic test_reset_midflight;
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A = 32'h1111_1111 * (i + 1); B = 32'h0000_0001; C_in = 1'b0; sub = 1'b0;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b1 || S !== 32'h1111_1112) begin
         errors++;
         $display("FAIL midflight_pre: got valid=%b S=%h, want 1/11111112", out_valid, S);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, S, C_out, ovf} !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midflight_reset: got valid=%b S=%h C=%b ovf=%b rdy=%b, want 0/0/0/0/1",
                  out_valid, S, C_out, ovf, in_ready);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midflight_stale: got %0d stale valid cycles, want 0", seen);
      end
      test_vector("after_reset", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0,
                  32'h0000_0031, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_vector("carry8", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      test_vector("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      test_vector("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      test_vector("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      test_vector("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      test_vector("sub_nobrw", 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0);
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Operands are split into CHUNK-bit slices; one slice is summed per pipeline stage, and the carry is registered between stages.
- Used where a WIDTH-bit combinational adder would not close timing.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be a multiple of CHUNK, and WIDTH >= CHUNK.
- CHUNK, 8: bits summed per stage. Number of stages NS = WIDTH/CHUNK.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A, unsigned or two's complement.
- B  in  WIDTH  operand B.
- C_in  in  1  carry-in (borrow-not when subtracting).
- sub  in  1  0: S = A + B + C_in; 1: S = A + ~B + C_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference.
- C_out  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.

Behaviour:
- Reset: all stage valid bits, out_valid, S, C_out, ovf and internal carries clear to 0 immediately on rst=1, independent of clk. in_ready = 1 during and after reset.
- Advance condition: adv = !out_valid || out_ready. The whole pipeline moves together when adv = 1 and holds every register when adv = 0.
- in_ready = adv, combinational. Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Operand capture:
  - B is inverted when sub = 1, before stage 0.
  - Stage 0 registers slice 0 sum/carry, together with the remaining upper slices of A and B', a valid bit, and the sign bits A[MSB] and B'[MSB].
- Stage k (1..NS-1) adds slice k of A and B' plus the registered carry from stage k-1. Completed lower slices are carried forward unchanged.
- Latency: a result accepted at edge t appears with out_valid = 1 after edge t+NS-1, i.e. NS cycles of valid after input acceptance with no stalls.
- Throughput: one result per cycle while out_ready = 1.
- Output flags:
  - S = concatenation of all slice sums.
  - C_out = carry out of the final slice.
  - ovf = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
  - C_out and ovf are updated with S.
- Bubbles: a cycle with in_valid = 0 and adv = 1 injects valid = 0 into stage 0; the bubble propagates normally.
- Stall: when out_valid && !out_ready, in_ready = 0 and S, C_out, ovf and out_valid hold stable until accepted. Data presented with in_valid = 1 while in_ready = 0 is not consumed; the source must hold it.
- Simultaneous in/out transfer in the same cycle is permitted, with no bubble inserted.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Operand order and C_in are preserved per transaction. sub and C_in are sampled with A and B.
- Reset mid-operation discards all in-flight results; no partial output is emitted.
- NS = 1 degenerates to a single registered adder with latency 1.

Test Plan:
- WIDTH=32, CHUNK=8, A=0x0000_00FF, B=0x0000_0001, C_in=0, sub=0 -> after 4 cycles: S=0x0000_0100, C_out=0, ovf=0. This exercises the inter-stage carry.
- A=0xFFFF_FFFF, B=0x0000_0000, C_in=1, sub=0 -> S=0x0000_0000, C_out=1, ovf=0. This covers a full-width ripple across all stages.
- sub=1, C_in=1, A=0x8000_0000, B=0x0000_0001 -> S=0x7FFF_FFFF, C_out=1, ovf=1. Also sub=1, C_in=1, A=5, B=7 -> S=0xFFFF_FFFE, C_out=0, ovf=0.
- Stream 10 back-to-back random operands with out_ready=1 -> 10 results on consecutive cycles, in order, matching the reference model {C_out,S} = A + (sub ? ~B : B) + C_in.
- Hold out_ready=0 for 6 cycles mid-stream -> in_ready=0 throughout the stall, outputs stable, no result lost or duplicated after release.
- Assert rst for 1 cycle, asynchronously between edges, with 3 results in flight -> out_valid=0 and S=0 immediately; no stale results emerge afterwards, and the next operand completes with latency 4.
